lut_gate_array: RTL and testbench
=================================

# lut_gate_array

Registered, parametrised array of programmable 2-input gates. Each output bit is a 4:1 mux over a 4-bit truth table, selected by the operand bit pair, so NAND, NOR, XOR, AND and any other 2-input function share one datapath. It sits between a valid/ready producer and consumer. It holds NUM_FN software-writable function slots and a transaction counter.

## Interface
- WIDTH, 8, operand/result width in bits
- NUM_FN, 4, number of truth-table slots (power of two, ≥2)
- CNT_W, 16, width of the completed-transaction counter

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand transaction offered
- in_ready  out  1  block can accept operands this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_fn  in  $clog2(NUM_FN)  function slot to apply
- out_valid  out  1  result held in output register
- out_ready  in  1  consumer takes result this cycle
- out_y  out  WIDTH  result
- cfg_we  in  1  truth-table write strobe
- cfg_slot  in  $clog2(NUM_FN)  slot written
- cfg_tt  in  4  new truth table
- done_cnt  out  CNT_W  count of results consumed

## Operation
- Truth table index is {a_bit, b_bit}: tt[0]=f(0,0), tt[1]=f(0,1), tt[2]=f(1,0), tt[3]=f(1,1).
- out_y[i] = tt_slot[in_fn][{in_a[i], in_b[i]}] for every bit i. The table is sampled at acceptance.
- Reset slot contents, in slot order: 0 NAND 4'b0111, 1 NOR 4'b0001, 2 XOR 4'b0110, 3 AND 4'b1000. Slots ≥4 reset to 4'b0000.
- Config write: when cfg_we=1, cfg_tt is stored into cfg_slot at the clock edge.
- Config write in the same cycle as an accept on that slot: the accepted transaction uses the old table. The new table applies from the next accept onward.
- Config writes never stall the datapath and never modify a result already in the output register.
- Accept condition: in_valid && in_ready.
- in_ready = !out_valid || out_ready. This is a single-stage pipeline register, combinational only through out_ready.
- Output register: on accept, load out_y and set out_valid. On out_ready && out_valid && !accept, clear out_valid.
- While out_valid=1 && out_ready=0, out_y stays stable.
- done_cnt increments on each out_valid && out_ready. It wraps from 2^CNT_W−1 to 0.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 result per cycle when out_ready is held high.
- Values while rst_n=0: out_valid=0, out_y=0, done_cnt=0, in_ready=1, slots at their reset values.
- Reset asserted mid-operation discards any pending result immediately. No output handshake completes for it.
- Simultaneous consume and accept: out_valid stays 1, out_y takes the new result, and done_cnt increments.
- Operands are ignored when in_valid=0. in_fn, in_a and in_b may change freely while not accepted.

## Structure
- Shared package lut_gate_pkg holds:
  - the TT_NAND/TT_NOR/TT_XOR/TT_AND constants (4'b0111/4'b0001/4'b0110/4'b1000);
  - the reset-table function indexed by slot.
- Sub-module lut2_mux: a 1-bit 4:1 mux (truth table, a, b → y), built from three mux2_1 instances.
  - Instantiate WIDTH copies of lut2_mux.
  - mux2_1 is the existing primitive.
- The top level contains the slot register file, the output pipeline register, the handshake logic and done_cnt.

## Test plan
- Reset defaults: a=8'hF0, b=8'hCC, fn=0..3 with out_ready=1.
  - Required out_y: 8'h3F (NAND), 8'h03 (NOR), 8'h3C (XOR), 8'hC0 (AND), each 1 cycle after accept.
  - done_cnt=4 afterwards.
- Reprogram: write slot 2 with 4'b1110 (OR), then a=8'hF0, b=8'hCC, fn=2 → out_y=8'hFC.
- Same-cycle write and accept on slot 0: accept a=8'hFF, b=8'hFF while writing 4'b1000 → out_y=8'h00 (old NAND). The next identical accept → out_y=8'hFF.
- Backpressure: hold out_ready=0 for 5 cycles after one accept.
  - in_ready=0, and out_y stays stable.
  - A second offer is not accepted until out_ready=1.
  - done_cnt increments by exactly 1 per consume.
- Streaming: 16 back-to-back accepts with out_ready=1 → 16 consecutive out_valid cycles, results in order, done_cnt=16.
- Async reset mid-flight: deassert rst_n while out_valid=1 and out_ready=0.
  - out_valid=0 and done_cnt=0 immediately, without waiting for a clock edge.
  - A previously rewritten slot 2 is back to XOR.

Source files
------------

// File: rtl/lut_gate_pkg.sv
// Shared constants and reset-table lookup for the programmable 2-input gate array.
// Latency: n/a (package).
// Backpressure: n/a (package).
package lut_gate_pkg;

   // Truth tables indexed by {a_bit, b_bit}: bit0=f(0,0) .. bit3=f(1,1)
   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_NOR  = 4'b0001;
   localparam logic [3:0] TT_XOR  = 4'b0110;
   localparam logic [3:0] TT_AND  = 4'b1000;

   // Power-on contents of each function slot; slots past the four defaults start empty
   function automatic logic [3:0] reset_tt(input int slot);
      case (slot)
         0:       reset_tt = TT_NAND;
         1:       reset_tt = TT_NOR;
         2:       reset_tt = TT_XOR;
         3:       reset_tt = TT_AND;
         default: reset_tt = 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/lut2_mux.sv
// 1-bit programmable 2-input gate: 4:1 mux over a truth table, selected by {a, b}.
// Latency: combinational.
// Backpressure: none.
module lut2_mux (
   input  logic [3:0] tt,
   input  logic       a,
   input  logic       b,
   output logic       y
);

   logic m_a0;
   logic m_a1;

   // First level picks on b within each a half, second level picks on a
   mux2_1 u_mux_a0 (.d0(tt[0]), .d1(tt[1]), .sel(b), .y(m_a0));
   mux2_1 u_mux_a1 (.d0(tt[2]), .d1(tt[3]), .sel(b), .y(m_a1));
   mux2_1 u_mux_y  (.d0(m_a0),  .d1(m_a1),  .sel(a), .y(y));

endmodule

// File: rtl/mux2_1.sv
// 1-bit 2:1 multiplexer primitive.
// Latency: combinational.
// Backpressure: none.
module mux2_1 (
   input  logic d0,
   input  logic d1,
   input  logic sel,
   output logic y
);

   // Select d1 when sel is high, otherwise d0
   always_comb begin
      y = sel ? d1 : d0;
   end

endmodule

// File: rtl/lut_gate_array.sv
// Registered array of programmable 2-input gates with software-writable function slots.
// Latency: 1 cycle from accept to out_valid; 1 result/cycle when out_ready is held high.
// Backpressure: in_ready = !out_valid || out_ready; result held stable while out_ready=0.
module lut_gate_array
   import lut_gate_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int NUM_FN = 4,
   parameter int CNT_W  = 16,
   localparam int FN_W  = $clog2(NUM_FN)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [FN_W-1:0]  in_fn,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_y,
   input  logic             cfg_we,
   input  logic [FN_W-1:0]  cfg_slot,
   input  logic [3:0]       cfg_tt,
   output logic [CNT_W-1:0] done_cnt
);

   logic [3:0]       tt_q [NUM_FN];
   logic [3:0]       tt_sel;
   logic [WIDTH-1:0] y_next;
   logic             accept;
   logic             consume;

   // Handshake: single-stage register, ready only depends on out_ready combinationally
   always_comb begin
      in_ready = !out_valid || out_ready;
      accept   = in_valid && in_ready;
      consume  = out_valid && out_ready;
   end

   // Table is read from the registered slot, so a same-cycle write is seen only by later accepts
   always_comb begin
      tt_sel = tt_q[in_fn];
   end

   // Slot register file; writes go straight in and never touch the output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < NUM_FN; s++) begin
            tt_q[s] <= reset_tt(s);
         end
      end else if (cfg_we) begin
         tt_q[cfg_slot] <= cfg_tt;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      lut2_mux u_lut (
         .tt (tt_sel),
         .a  (in_a[i]),
         .b  (in_b[i]),
         .y  (y_next[i])
      );
   end

   // Output pipeline register: load on accept, drop valid when consumed without refill
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_y     <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_y     <= y_next;
      end else if (consume) begin
         out_valid <= 1'b0;
      end
   end

   // Count consumed results, wrapping naturally at 2^CNT_W
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_cnt <= '0;
      end else if (consume) begin
         done_cnt <= done_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_lut_gate_array.sv
// Directed testbench for lut_gate_array with hand-computed expected results.
// Latency: checks outputs 1 cycle after each accept.
// Backpressure: exercises out_ready=0 hold and release.
module tb_lut_gate_array;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_a;
   logic [7:0]  in_b;
   logic [1:0]  in_fn;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_y;
   logic        cfg_we;
   logic [1:0]  cfg_slot;
   logic [3:0]  cfg_tt;
   logic [15:0] done_cnt;

   int n_checks;
   int n_fail;
   logic [3:0] exp_tt [4];

   lut_gate_array #(.WIDTH(8), .NUM_FN(4), .CNT_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_fn     (in_fn),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .cfg_we    (cfg_we),
      .cfg_slot  (cfg_slot),
      .cfg_tt    (cfg_tt),
      .done_cnt  (done_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference gate function straight from the truth-table definition
   function automatic logic [7:0] gate_ref(input logic [3:0] tt, input logic [7:0] a,
                                           input logic [7:0] b);
      logic [7:0] y;
      for (int i = 0; i < 8; i++) begin
         case ({a[i], b[i]})
            2'b00:   y[i] = tt[0];
            2'b01:   y[i] = tt[1];
            2'b10:   y[i] = tt[2];
            default: y[i] = tt[3];
         endcase
      end
      return y;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_fn = '0;
      out_ready = 1'b0; cfg_we = 1'b0; cfg_slot = '0; cfg_tt = '0;
      exp_tt[0] = 4'b0111; exp_tt[1] = 4'b0001; exp_tt[2] = 4'b0110; exp_tt[3] = 4'b1000;
      #3;
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_checks++;
      if (out_y !== 8'h00) begin n_fail++; $display("FAIL reset_out_y: got %h want 00", out_y); end
      n_checks++;
      if (done_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_done_cnt: got %0d want 0", done_cnt); end
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_defaults();
      logic [7:0] want [4];
      want[0] = 8'h3F; want[1] = 8'h03; want[2] = 8'h3C; want[3] = 8'hC0;
      out_ready = 1'b1;
      in_a = 8'hF0; in_b = 8'hCC;
      for (int f = 0; f < 4; f++) begin
         in_valid = 1'b1; in_fn = 2'(f);
         tick();
         n_checks++;
         if (out_valid !== 1'b1 || out_y !== want[f]) begin
            n_fail++;
            $display("FAIL default_fn%0d: got valid=%b y=%h want valid=1 y=%h", f, out_valid, out_y, want[f]);
         end
      end
      in_valid = 1'b0;
      tick();
      n_checks++;
      if (done_cnt !== 16'd4 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL default_drain: got cnt=%0d valid=%b want cnt=4 valid=0", done_cnt, out_valid);
      end
   endtask

   task automatic test_reprogram();
      cfg_we = 1'b1; cfg_slot = 2'd2; cfg_tt = 4'b1110;
      tick();
      exp_tt[2] = 4'b1110;
      cfg_we = 1'b0;
      in_valid = 1'b1; in_a = 8'hF0; in_b = 8'hCC; in_fn = 2'd2;
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || out_y !== 8'hFC) begin
         n_fail++;
         $display("FAIL reprogram_or: got valid=%b y=%h want valid=1 y=fc", out_valid, out_y);
      end
      tick();
   endtask

   task automatic test_same_cycle_write();
      cfg_we = 1'b1; cfg_slot = 2'd0; cfg_tt = 4'b1000;
      in_valid = 1'b1; in_a = 8'hFF; in_b = 8'hFF; in_fn = 2'd0;
      tick();
      exp_tt[0] = 4'b1000;
      cfg_we = 1'b0;
      n_checks++;
      if (out_y !== 8'h00) begin n_fail++; $display("FAIL same_cycle_old_tt: got %h want 00", out_y); end
      tick();
      n_checks++;
      if (out_y !== 8'hFF) begin n_fail++; $display("FAIL same_cycle_new_tt: got %h want ff", out_y); end
      in_valid = 1'b0;
      tick();
      n_checks++;
      if (done_cnt !== 16'd7) begin n_fail++; $display("FAIL same_cycle_cnt: got %0d want 7", done_cnt); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      in_valid = 1'b1; in_a = 8'hF0; in_b = 8'hCC; in_fn = 2'd3;
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_y !== 8'hC0) begin
         n_fail++;
         $display("FAIL bp_first: got valid=%b y=%h want valid=1 y=c0", out_valid, out_y);
      end
      // second offer: AND of 0F,0F = 0F, also exercise a config write during the stall
      in_a = 8'h0F; in_b = 8'h0F; in_fn = 2'd3;
      for (int c = 0; c < 5; c++) begin
         cfg_we = (c == 2); cfg_slot = 2'd1; cfg_tt = 4'b0001;
         n_checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_y !== 8'hC0) begin
            n_fail++;
            $display("FAIL bp_hold%0d: got rdy=%b valid=%b y=%h want rdy=0 valid=1 y=c0",
                     c, in_ready, out_valid, out_y);
         end
         tick();
      end
      cfg_we = 1'b0;
      n_checks++;
      if (done_cnt !== 16'd7 || out_y !== 8'hC0) begin
         n_fail++;
         $display("FAIL bp_stalled: got cnt=%0d y=%h want cnt=7 y=c0", done_cnt, out_y);
      end
      out_ready = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_rdy: got %b want 1", in_ready); end
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (done_cnt !== 16'd8 || out_valid !== 1'b1 || out_y !== 8'h0F) begin
         n_fail++;
         $display("FAIL bp_swap: got cnt=%0d valid=%b y=%h want cnt=8 valid=1 y=0f",
                  done_cnt, out_valid, out_y);
      end
      tick();
      n_checks++;
      if (done_cnt !== 16'd9 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_drain: got cnt=%0d valid=%b want cnt=9 valid=0", done_cnt, out_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] cnt0;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [7:0]  want;
      int          valid_run;
      cnt0 = done_cnt;
      valid_run = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         a = 8'h3A + 8'(i * 29);
         b = 8'(i * 53) ^ 8'hA5;
         in_valid = 1'b1; in_a = a; in_b = b; in_fn = 2'(i % 4);
         want = gate_ref(exp_tt[i % 4], a, b);
         tick();
         if (out_valid === 1'b1) valid_run++;
         n_checks++;
         if (out_y !== want) begin
            n_fail++;
            $display("FAIL stream%0d: got %h want %h", i, out_y, want);
         end
      end
      in_valid = 1'b0;
      tick();
      n_checks++;
      if (valid_run != 16) begin n_fail++; $display("FAIL stream_valid_run: got %0d want 16", valid_run); end
      n_checks++;
      if (done_cnt - cnt0 !== 16'd16) begin
         n_fail++;
         $display("FAIL stream_cnt: got delta %0d want 16", done_cnt - cnt0);
      end
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      in_valid = 1'b1; in_a = 8'h55; in_b = 8'hAA; in_fn = 2'd2;
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL arst_pre_valid: got %b want 1", out_valid); end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || done_cnt !== 16'd0 || in_ready !== 1'b1 || out_y !== 8'h00) begin
         n_fail++;
         $display("FAIL arst_immediate: got valid=%b cnt=%0d rdy=%b y=%h want 0 0 1 00",
                  out_valid, done_cnt, in_ready, out_y);
      end
      tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b1; in_a = 8'hF0; in_b = 8'hCC; in_fn = 2'd2;
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (out_y !== 8'h3C) begin n_fail++; $display("FAIL arst_slot2_xor: got %h want 3c", out_y); end
      tick();
      n_checks++;
      if (done_cnt !== 16'd1) begin n_fail++; $display("FAIL arst_cnt_restart: got %0d want 1", done_cnt); end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_defaults();
      test_reprogram();
      test_same_cycle_write();
      test_backpressure();
      test_back_to_back();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
